sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Time-slices one external asynchronous SRAM between the video fetch path and up to `NUM_CLIENTS` independent read/write clients. The scheduler runs a fixed 4-cycle frame with one guaranteed video read slot and one client slot. The client slot is granted round-robin among requesters. The block sits between the video output pipeline / drawing engines and the SRAM pins, and generalises the single-client memory manager in address width, data width and client count.

## Interface
- `ADDR_WIDTH`, 17: SRAM address width.
- `DATA_WIDTH`, 8: SRAM data width.
- `NUM_CLIENTS`, 2: number of client ports, ≥1.
- `clock` input 1: single clock; everything is on its rising edge.
- `reset` input 1: synchronous, active-low (0 = in reset).
- `videoAddress` input ADDR_WIDTH: address for the next video fetch.
- `videoData` output DATA_WIDTH: last fetched video byte.
- `videoDataReady` output 1: one-cycle strobe; `videoData` is updated.
- `clientRequest` input NUM_CLIENTS: per-client request level.
- `clientWrite` input NUM_CLIENTS: 1 = write, 0 = read; qualified by request.
- `clientAddress` input NUM_CLIENTS*ADDR_WIDTH: flattened; client i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `clientWriteData` input NUM_CLIENTS*DATA_WIDTH: flattened, same packing.
- `clientReadData` output DATA_WIDTH: shared read-return register.
- `clientComplete` output NUM_CLIENTS: one-hot, one-cycle completion strobe.
- `ramAddress` output ADDR_WIDTH: SRAM address.
- `ramData` inout DATA_WIDTH: SRAM data bus.
- `ramOutputEnable` output 1: SRAM OE, active-low.
- `ramWriteEnable` output 1: SRAM WE, active-low.

## Operation
- Phase register cycles IDLE → VIDEO → ACCESS → COMPLETE → IDLE. It never stalls; each frame is exactly 4 cycles.
- All SRAM outputs are registered. Their values during a phase are loaded at the edge entering that phase.
- **IDLE**
  - `ramAddress` = `videoAddress`.
  - OE = 1, WE = 1.
- **VIDEO**
  - `ramAddress` = `videoAddress` (sampled at the edge entering VIDEO); OE = 0.
  - Arbitration is combinational during VIDEO. The grant goes to the first i with `clientRequest[i]`=1, scanning from `rrPointer` upward and wrapping NUM_CLIENTS-1 → 0.
  - At the edge leaving VIDEO:
    - `videoData` ← `ramData`.
    - Latch grant index, `grantValid`, `clientWrite`, address and write data of the winner.
- **ACCESS**
  - `videoDataReady` = 1.
  - If `grantValid`:
    - `ramAddress` = latched client address.
    - Read: OE = 0.
    - Write: WE = 0, OE = 1, and `ramData` driven with latched write data.
  - If not `grantValid`: NOP, with OE = WE = 1.
  - At the edge leaving ACCESS, if `grantValid`:
    - Read: `clientReadData` ← `ramData`.
    - `rrPointer` ← (grant + 1) mod NUM_CLIENTS.
- **COMPLETE**
  - `clientComplete[grant]` = 1 if `grantValid`.
  - OE = WE = 1. `ramData` is still driven for a granted write (hold time), and released at the edge entering IDLE.
- `ramData` is Z at all other times.
- Client contract:
  - Hold `clientRequest`/`clientWrite`/address/data stable until `clientComplete[i]`.
  - Drop or replace the request by the edge after `clientComplete[i]`.
  - Withdrawal before being granted is legal; the client is simply not served.
- Request rising outside VIDEO: considered at the next VIDEO phase.

## Timing
- Reset (reset = 0 at an edge):
  - phase = IDLE, `rrPointer` = 0, `grantValid` = 0.
  - `ramAddress` = 0, OE = 1, WE = 1, `ramData` = Z.
  - `videoData` = 0, `videoDataReady` = 0, `clientReadData` = 0, `clientComplete` = 0.
- Reset asserted mid-frame: an in-flight access is abandoned with no `clientComplete`. WE deasserts at that same edge.
- Video: one fetch per 4 cycles. `videoData` is valid from the ACCESS cycle, when `videoDataReady` pulses.
- Client latency: request present during VIDEO → `clientComplete` 2 cycles later; read data is valid in the same cycle.
- Worst-case wait with all clients requesting: NUM_CLIENTS frames (4·NUM_CLIENTS cycles) plus 2.
- Fairness: a continuously requesting client is served at least once every NUM_CLIENTS frames.
- NUM_CLIENTS = 1: the pointer is constant 0 and the grant index width is clamped to 1 bit.

## Structure
- `sram_arbiter_pkg`: phase enum typedef (IDLE, VIDEO, ACCESS, COMPLETE) and the frame-length constant.
- Sub-module `rr_arbiter`:
  - Parameter NUM_CLIENTS.
  - Inputs: request vector, pointer. Outputs: grant index, grant valid.
  - Purely combinational.
- The top holds the phase register, latches, SRAM output registers and tri-state.

## Test plan
- Idle bus, `videoAddress` = 0x00123 with SRAM model returning 0x5A → `ramAddress` = 0x00123 and OE = 0 in VIDEO; `videoData` = 0x5A with `videoDataReady` = 1 in ACCESS; no `clientComplete`.
- Client 1 write, addr 0x1ABCD, data 0xC3 → WE low for exactly the ACCESS cycle at 0x1ABCD, `ramData` = 0xC3 through COMPLETE, `clientComplete` = 2'b10 for one cycle. A subsequent client 0 read of 0x1ABCD returns 0xC3.
- NUM_CLIENTS = 3, all requesting continuously → grants 0, 1, 2, 0 in successive frames; each complete strobe is 4 cycles apart.
- Client 0 request rising during COMPLETE → not served until the next VIDEO; complete arrives 4 cycles after the rise.
- Reset driven low during the ACCESS of a write → WE = 1 at that edge, no complete, phase IDLE, `ramData` = Z; normal frames resume 1 cycle after release.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the SRAM time-slice arbiter.
package sram_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      VIDEO    = 2'd1,
      ACCESS   = 2'd2,
      COMPLETE = 2'd3
   } phaseType;

   localparam int FRAME_LENGTH = 4;

   // A single client still needs a one-bit grant index.
   function automatic int grantWidth(input int numClients);
      return (numClients > 1) ? $clog2(numClients) : 1;
   endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Video fetch and client request/response bundle between the engines and the arbiter.
interface sram_arbiter_if #(
   parameter int ADDR_WIDTH  = 17,
   parameter int DATA_WIDTH  = 8,
   parameter int NUM_CLIENTS = 2
);
   logic [ADDR_WIDTH-1:0]             videoAddress;
   logic [DATA_WIDTH-1:0]             videoData;
   logic                              videoDataReady;
   logic [NUM_CLIENTS-1:0]            clientRequest;
   logic [NUM_CLIENTS-1:0]            clientWrite;
   logic [NUM_CLIENTS*ADDR_WIDTH-1:0] clientAddress;
   logic [NUM_CLIENTS*DATA_WIDTH-1:0] clientWriteData;
   logic [DATA_WIDTH-1:0]             clientReadData;
   logic [NUM_CLIENTS-1:0]            clientComplete;

   modport master (
      output videoAddress, clientRequest, clientWrite, clientAddress, clientWriteData,
      input  videoData, videoDataReady, clientReadData, clientComplete
   );

   modport slave (
      input  videoAddress, clientRequest, clientWrite, clientAddress, clientWriteData,
      output videoData, videoDataReady, clientReadData, clientComplete
   );
endinterface

// File: rtl/sram_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
module rr_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter  int NUM_CLIENTS = 2,
   localparam int GW          = grantWidth(NUM_CLIENTS)
) (
   input  logic [NUM_CLIENTS-1:0] request,
   input  logic [GW-1:0]          pointer,
   output logic [GW-1:0]          grantIndex,
   output logic                   grantValid
);

   // Scan from the far end so the requester closest to the pointer is written last.
   always_comb begin
      grantIndex = '0;
      grantValid = 1'b0;
      for (int offset = NUM_CLIENTS - 1; offset >= 0; offset--) begin
         if (request[(int'(pointer) + offset) % NUM_CLIENTS]) begin
            grantIndex = GW'((int'(pointer) + offset) % NUM_CLIENTS);
            grantValid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Four-cycle frame scheduler sharing one async SRAM between video fetch and round-robin clients.
//  phase    | meaning
//  IDLE     | bus quiet, video address presented
//  VIDEO    | video read (OE low), client arbitration
//  ACCESS   | granted client read/write, videoDataReady strobe
//  COMPLETE | clientComplete strobe, write data held
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH  = 17,
   parameter int DATA_WIDTH  = 8,
   parameter int NUM_CLIENTS = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   sram_arbiter_if.slave         bus,
   output logic [ADDR_WIDTH-1:0] ramAddress,
   inout  wire  [DATA_WIDTH-1:0] ramData,
   output logic                  ramOutputEnable,
   output logic                  ramWriteEnable
);

   localparam int GW = grantWidth(NUM_CLIENTS);

   phaseType              phase, nextPhase;
   logic [GW-1:0]         rrPointer;
   logic [GW-1:0]         arbIndex;
   logic                  arbValid;
   logic [GW-1:0]         grantIndex;
   logic                  grantValid;
   logic                  grantWrite;
   logic [DATA_WIDTH-1:0] writeData;
   logic                  driveEnable;
   logic [GW-1:0]         pointerAfterGrant;

   rr_arbiter #(.NUM_CLIENTS(NUM_CLIENTS)) arbiter (
      .request    (bus.clientRequest),
      .pointer    (rrPointer),
      .grantIndex (arbIndex),
      .grantValid (arbValid)
   );

   always_ff @(posedge clock) begin
      if (!reset) phase <= IDLE;
      else        phase <= nextPhase;
   end

   always_comb begin
      nextPhase = IDLE;
      case (phase)
         IDLE:     nextPhase = VIDEO;
         VIDEO:    nextPhase = ACCESS;
         ACCESS:   nextPhase = COMPLETE;
         COMPLETE: nextPhase = IDLE;
         default:  nextPhase = IDLE;
      endcase
   end

   assign pointerAfterGrant = (int'(grantIndex) == NUM_CLIENTS - 1) ? '0 : grantIndex + GW'(1);

   // Write data stays on the bus through COMPLETE for SRAM hold time.
   assign ramData = driveEnable ? writeData : 'z;

   always_ff @(posedge clock) begin
      if (!reset) begin
         rrPointer          <= '0;
         grantIndex         <= '0;
         grantValid         <= 1'b0;
         grantWrite         <= 1'b0;
         writeData          <= '0;
         driveEnable        <= 1'b0;
         ramAddress         <= '0;
         ramOutputEnable    <= 1'b1;
         ramWriteEnable     <= 1'b1;
         bus.videoData      <= '0;
         bus.videoDataReady <= 1'b0;
         bus.clientReadData <= '0;
         bus.clientComplete <= '0;
      end else begin
         bus.videoDataReady <= 1'b0;
         bus.clientComplete <= '0;
         case (phase)
            IDLE: begin
               ramAddress      <= bus.videoAddress;
               ramOutputEnable <= 1'b0;
               ramWriteEnable  <= 1'b1;
            end
            VIDEO: begin
               bus.videoData      <= ramData;
               bus.videoDataReady <= 1'b1;
               grantIndex         <= arbIndex;
               grantValid         <= arbValid;
               grantWrite         <= bus.clientWrite[arbIndex];
               writeData          <= bus.clientWriteData[arbIndex*DATA_WIDTH +: DATA_WIDTH];
               if (arbValid) begin
                  ramAddress      <= bus.clientAddress[arbIndex*ADDR_WIDTH +: ADDR_WIDTH];
                  ramOutputEnable <= bus.clientWrite[arbIndex];
                  ramWriteEnable  <= ~bus.clientWrite[arbIndex];
                  driveEnable     <= bus.clientWrite[arbIndex];
               end else begin
                  ramOutputEnable <= 1'b1;
                  ramWriteEnable  <= 1'b1;
               end
            end
            ACCESS: begin
               ramOutputEnable <= 1'b1;
               ramWriteEnable  <= 1'b1;
               if (grantValid) begin
                  if (!grantWrite) bus.clientReadData <= ramData;
                  bus.clientComplete <= NUM_CLIENTS'(1) << grantIndex;
                  rrPointer          <= pointerAfterGrant;
               end
            end
            COMPLETE: begin
               ramAddress      <= bus.videoAddress;
               ramOutputEnable <= 1'b1;
               ramWriteEnable  <= 1'b1;
               driveEnable     <= 1'b0;
               grantValid      <= 1'b0;
            end
            default: begin
               ramOutputEnable <= 1'b1;
               ramWriteEnable  <= 1'b1;
               driveEnable     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with an SRAM model and a frame-level reference model.
module tb_sram_arbiter;

   localparam int AW = 17;
   localparam int DW = 8;
   localparam int NC = 3;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   sram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CLIENTS(NC)) bus ();

   wire  [DW-1:0] ramData;
   logic [AW-1:0] ramAddress;
   logic          ramOutputEnable;
   logic          ramWriteEnable;

   sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CLIENTS(NC)) dut (
      .clock           (clock),
      .reset           (reset),
      .bus             (bus),
      .ramAddress      (ramAddress),
      .ramData         (ramData),
      .ramOutputEnable (ramOutputEnable),
      .ramWriteEnable  (ramWriteEnable)
   );

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   function automatic logic [DW-1:0] initPattern(input logic [AW-1:0] a);
      if (a == 17'h00123) return 8'h5A;
      return a[7:0] ^ a[15:8] ^ {7'b0, a[16]} ^ 8'h96;
   endfunction

   // Asynchronous SRAM: reads while OE low and WE high, writes while WE low.
   logic [DW-1:0] sramMem [0:(1<<AW)-1];
   initial for (int i = 0; i < (1 << AW); i++) sramMem[i] = initPattern(AW'(i));
   assign ramData = (!ramOutputEnable && ramWriteEnable) ? sramMem[ramAddress] : 'z;
   always @(negedge clock) if (!ramWriteEnable) sramMem[ramAddress] <= ramData;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Reference model: slot counts cycles within the frame since reset release.
   int            slot = 0;
   bit            modelArmed = 0;
   int            lastServed = NC - 1;
   bit            mServing = 0;
   int            mClient = 0;
   bit            mWrite = 0;
   logic [AW-1:0] mAddr = '0;
   logic [DW-1:0] mData = '0;
   logic [DW-1:0] modelWritten [int];

   logic [AW-1:0] expAddr = '0;
   logic          expOE = 1'b1, expWE = 1'b1, expVDR = 1'b0, expDrive = 1'b0;
   logic [DW-1:0] expVD = '0, expCRD = '0, expWData = '0;
   logic [NC-1:0] expCC = '0;

   function automatic logic [DW-1:0] modelRead(input logic [AW-1:0] a);
      if (modelWritten.exists(int'(a))) return modelWritten[int'(a)];
      return initPattern(a);
   endfunction

   // Winner is the requester nearest after the last served client.
   task automatic pick();
      int best = NC;
      mServing = 0;
      for (int i = 0; i < NC; i++) begin
         if (bus.clientRequest[i]) begin
            int d = (i - lastServed - 1 + 2 * NC) % NC;
            if (d < best) begin
               best    = d;
               mClient = i;
            end
         end
      end
      if (best < NC) begin
         mServing = 1;
         mWrite   = bus.clientWrite[mClient];
         mAddr    = bus.clientAddress[mClient*AW +: AW];
         mData    = bus.clientWriteData[mClient*DW +: DW];
      end
   endtask

   task automatic modelStep();
      if (!reset) begin
         slot = 0; lastServed = NC - 1; mServing = 0; modelArmed = 1;
         expAddr = '0; expOE = 1; expWE = 1; expVD = '0; expVDR = 0;
         expCRD = '0; expCC = '0; expDrive = 0;
         return;
      end
      if (!modelArmed) return;
      expCC  = '0;
      expVDR = 0;
      case (slot)
         0: begin expAddr = bus.videoAddress; expOE = 0; expWE = 1; end
         1: begin
            expVD  = modelRead(expAddr);
            expVDR = 1;
            pick();
            expOE = 1; expWE = 1;
            if (mServing) begin
               expAddr  = mAddr;
               expOE    = mWrite;
               expWE    = !mWrite;
               expDrive = mWrite;
               expWData = mData;
               if (mWrite) modelWritten[int'(mAddr)] = mData;
            end
         end
         2: begin
            expOE = 1; expWE = 1;
            if (mServing) begin
               if (!mWrite) expCRD = modelRead(mAddr);
               expCC      = NC'(1 << mClient);
               lastServed = mClient;
            end
         end
         default: begin
            expAddr = bus.videoAddress; expOE = 1; expWE = 1; expDrive = 0; mServing = 0;
         end
      endcase
      slot = (slot + 1) % 4;
   endtask

   task automatic compareAll();
      check("ramAddress", 32'(ramAddress), 32'(expAddr));
      check("ramOutputEnable", 32'(ramOutputEnable), 32'(expOE));
      check("ramWriteEnable", 32'(ramWriteEnable), 32'(expWE));
      check("videoData", 32'(bus.videoData), 32'(expVD));
      check("videoDataReady", 32'(bus.videoDataReady), 32'(expVDR));
      check("clientReadData", 32'(bus.clientReadData), 32'(expCRD));
      check("clientComplete", 32'(bus.clientComplete), 32'(expCC));
      if (expDrive) check("ramData drive", 32'(ramData), 32'(expWData));
   endtask

   initial begin
      forever begin
         @(posedge clock);
         modelStep();
         cycle++;
         @(negedge clock);
         if (modelArmed) compareAll();
      end
   end

   task automatic nextCycle();
      @(negedge clock);
   endtask

   task automatic setClient(input int i, input bit req, input bit wr,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.clientRequest[i]             = req;
      bus.clientWrite[i]               = wr;
      bus.clientAddress[i*AW +: AW]    = a;
      bus.clientWriteData[i*DW +: DW]  = d;
   endtask

   logic [NC-1:0] grantSeq [4];
   int            lastComplete;
   int            waited;

   initial begin
      grantSeq[0] = 3'b001; grantSeq[1] = 3'b010; grantSeq[2] = 3'b100; grantSeq[3] = 3'b001;
      bus.videoAddress    = 17'h00123;
      bus.clientRequest   = '0;
      bus.clientWrite     = '0;
      bus.clientAddress   = '0;
      bus.clientWriteData = '0;
      reset = 1'b0;
      repeat (3) nextCycle();

      check("rst ramAddress", 32'(ramAddress), 32'h0);
      check("rst OE", 32'(ramOutputEnable), 32'h1);
      check("rst WE", 32'(ramWriteEnable), 32'h1);
      check("rst videoData", 32'(bus.videoData), 32'h0);
      check("rst videoDataReady", 32'(bus.videoDataReady), 32'h0);
      check("rst clientReadData", 32'(bus.clientReadData), 32'h0);
      check("rst clientComplete", 32'(bus.clientComplete), 32'h0);

      // Idle-bus video fetch
      reset = 1'b1;
      nextCycle();
      check("video ramAddress", 32'(ramAddress), 32'h00123);
      check("video OE", 32'(ramOutputEnable), 32'h0);
      nextCycle();
      check("video data", 32'(bus.videoData), 32'h5A);
      check("video ready", 32'(bus.videoDataReady), 32'h1);
      check("nop OE", 32'(ramOutputEnable), 32'h1);
      nextCycle();
      check("nop complete", 32'(bus.clientComplete), 32'h0);

      // All clients requesting: raised during COMPLETE
      bus.videoAddress = 17'h01000;
      for (int i = 0; i < NC; i++) setClient(i, 1'b1, 1'b0, AW'(17'h00200 + i), 8'h00);
      lastComplete = cycle;
      for (int k = 0; k < 4; k++) begin
         waited = 0;
         do begin
            nextCycle();
            waited++;
         end while (bus.clientComplete == '0 && waited < 12);
         check("rr grant", 32'(bus.clientComplete), 32'(grantSeq[k]));
         check("rr interval", 32'(cycle - lastComplete), 32'd4);
         lastComplete = cycle;
      end

      // Client 1 write, others drop
      setClient(0, 1'b0, 1'b0, '0, '0);
      setClient(2, 1'b0, 1'b0, '0, '0);
      setClient(1, 1'b1, 1'b1, 17'h1ABCD, 8'hC3);
      nextCycle();
      check("wr idle WE", 32'(ramWriteEnable), 32'h1);
      nextCycle();
      check("wr video WE", 32'(ramWriteEnable), 32'h1);
      nextCycle();
      check("wr access WE", 32'(ramWriteEnable), 32'h0);
      check("wr access OE", 32'(ramOutputEnable), 32'h1);
      check("wr access addr", 32'(ramAddress), 32'h1ABCD);
      check("wr access data", 32'(ramData), 32'hC3);
      nextCycle();
      check("wr complete WE", 32'(ramWriteEnable), 32'h1);
      check("wr hold data", 32'(ramData), 32'hC3);
      check("wr complete", 32'(bus.clientComplete), 32'b010);

      // Client 0 reads back, rising during COMPLETE
      setClient(1, 1'b0, 1'b0, '0, '0);
      setClient(0, 1'b1, 1'b0, 17'h1ABCD, 8'h00);
      lastComplete = cycle;
      nextCycle();
      check("rd idle complete", 32'(bus.clientComplete), 32'h0);
      check("rd idle WE", 32'(ramWriteEnable), 32'h1);
      nextCycle();
      check("rd video complete", 32'(bus.clientComplete), 32'h0);
      nextCycle();
      check("rd access OE", 32'(ramOutputEnable), 32'h0);
      check("rd access addr", 32'(ramAddress), 32'h1ABCD);
      nextCycle();
      check("rd complete", 32'(bus.clientComplete), 32'b001);
      check("rd latency", 32'(cycle - lastComplete), 32'd4);
      check("rd data", 32'(bus.clientReadData), 32'hC3);

      // Reset during the ACCESS of a client 2 write
      setClient(0, 1'b0, 1'b0, '0, '0);
      setClient(2, 1'b1, 1'b1, 17'h00ABC, 8'h3C);
      repeat (3) nextCycle();
      check("rst-wr access WE", 32'(ramWriteEnable), 32'h0);
      reset = 1'b0;
      nextCycle();
      check("rst-wr WE", 32'(ramWriteEnable), 32'h1);
      check("rst-wr OE", 32'(ramOutputEnable), 32'h1);
      check("rst-wr addr", 32'(ramAddress), 32'h0);
      check("rst-wr complete", 32'(bus.clientComplete), 32'h0);
      reset = 1'b1;
      setClient(2, 1'b0, 1'b0, '0, '0);
      nextCycle();
      check("resume OE", 32'(ramOutputEnable), 32'h0);
      check("resume addr", 32'(ramAddress), 32'h01000);
      nextCycle();
      check("resume ready", 32'(bus.videoDataReady), 32'h1);
      nextCycle();
      check("resume complete", 32'(bus.clientComplete), 32'h0);

      // Mixed traffic under the model only
      bus.videoAddress = 17'h1ABCD;
      setClient(1, 1'b1, 1'b0, 17'h00ABC, 8'h00);
      setClient(2, 1'b1, 1'b1, 17'h00123, 8'hE7);
      repeat (12) nextCycle();
      setClient(1, 1'b0, 1'b0, '0, '0);
      setClient(2, 1'b0, 1'b0, '0, '0);
      repeat (4) nextCycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
